// File: rtl/display_pkg.sv
// Shared constants and helpers for the paged BCD display path.
package display_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Ceiling log2, used for sizing counters and indices from parameters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bcd_lz_blank.sv
// Replaces every digit above the most significant nonzero digit with the blank code.
module bcd_lz_blank
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 9
) (
    input  logic [4*NUM_DIGITS-1:0] snap,
    output logic [4*NUM_DIGITS-1:0] blanked
);

    logic seen;

    // Scan from the top; digit 0 always counts as significant so a zero value shows "0".
    always_comb begin
        seen    = 1'b0;
        blanked = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (snap[4*i +: 4] != 4'h0 || i == 0) seen = 1'b1;
            blanked[4*i +: 4] = seen ? snap[4*i +: 4] : BLANK_CODE;
        end
    end

endmodule

// File: rtl/bcd_page_display.sv
// Shows an N-digit BCD snapshot on a D-digit display, one page at a time,
// most significant page first, with optional blank lead-in page.
module bcd_page_display
    import display_pkg::*;
#(
    parameter int  NUM_DIGITS  = 9,
    parameter int  DISP_DIGITS = 3,
    parameter int  DWELL       = 25_000_000,
    parameter int  BLANK_PAGE  = 1,
    parameter int  LZ_BLANK    = 1,
    localparam int DATA_PAGES  = (NUM_DIGITS + DISP_DIGITS - 1) / DISP_DIGITS,
    localparam int NUM_PAGES   = DATA_PAGES + BLANK_PAGE,
    localparam int PW          = (clog2(NUM_PAGES) < 1) ? 1 : clog2(NUM_PAGES)
) (
    input  logic                     CLOCK_50,
    input  logic                     rst_n,
    input  logic [4*NUM_DIGITS-1:0]  digits_in,
    input  logic                     sign_in,
    input  logic                     load,
    input  logic                     hold,
    input  logic                     step,
    output logic [4*DISP_DIGITS-1:0] seg_bcd,
    output logic                     sign_out,
    output logic [PW-1:0]            page_idx,
    output logic                     sweep_done
);

    localparam int              CW        = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
    localparam int              SEG_W     = 4 * DISP_DIGITS;
    localparam int              PAD_W     = SEG_W * DATA_PAGES;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DWELL - 1);
    localparam logic [PW-1:0]   PAGE_LAST = PW'(NUM_PAGES - 1);

    logic [4*NUM_DIGITS-1:0] snap, snap_nxt, lz_digits, shown;
    logic                    snap_sign, snap_sign_nxt, snap_valid;
    logic [CW-1:0]           dwell_cnt, cnt_nxt;
    logic [PW-1:0]           page_nxt;
    logic                    done_nxt, advance, take_snap;
    logic [PAD_W-1:0]        padded;
    logic [SEG_W-1:0]        seg_nxt;
    logic                    sign_out_nxt;
    int                      page_int, grp;

    // load and step are one-cycle pulses sampled on the clock edge; load wins
    // over step, step (only while hold=1) wins over dwell expiry (only while hold=0).
    always_comb begin
        advance  = 1'b0;
        page_nxt = page_idx;
        cnt_nxt  = dwell_cnt;
        done_nxt = 1'b0;
        if (load) begin
            page_nxt = '0;
            cnt_nxt  = '0;
        end else if (hold) begin
            if (step) begin
                advance = 1'b1;
                cnt_nxt = '0;
            end
        end else if (dwell_cnt == CNT_LAST) begin
            advance = 1'b1;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = dwell_cnt + CW'(1);
        end
        if (advance) begin
            if (page_idx == PAGE_LAST) begin
                page_nxt = '0;
                done_nxt = 1'b1;
            end else begin
                page_nxt = page_idx + PW'(1);
            end
        end
        take_snap     = load || !snap_valid || (advance && page_idx == PAGE_LAST);
        snap_nxt      = take_snap ? digits_in : snap;
        snap_sign_nxt = take_snap ? sign_in : snap_sign;
    end

    // Outputs are registered from the next snapshot and page so they move with page_idx.
    bcd_lz_blank #(.NUM_DIGITS(NUM_DIGITS)) u_lz (
        .snap    (snap_nxt),
        .blanked (lz_digits)
    );

    assign shown = (LZ_BLANK != 0) ? lz_digits : snap_nxt;

    always_comb begin
        padded = {PAD_W{1'b1}};
        padded[4*NUM_DIGITS-1:0] = shown;
    end

    always_comb begin
        seg_nxt      = {DISP_DIGITS{BLANK_CODE}};
        sign_out_nxt = 1'b0;
        page_int     = int'(page_nxt);
        grp          = 0;
        if (page_int >= BLANK_PAGE && page_int < NUM_PAGES) begin
            grp          = DATA_PAGES - 1 - (page_int - BLANK_PAGE);
            seg_nxt      = padded[grp*SEG_W +: SEG_W];
            sign_out_nxt = snap_sign_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            snap       <= '0;
            snap_sign  <= 1'b0;
            snap_valid <= 1'b0;
            dwell_cnt  <= '0;
            page_idx   <= '0;
            seg_bcd    <= {DISP_DIGITS{BLANK_CODE}};
            sign_out   <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            snap       <= snap_nxt;
            snap_sign  <= snap_sign_nxt;
            snap_valid <= 1'b1;
            dwell_cnt  <= cnt_nxt;
            page_idx   <= page_nxt;
            seg_bcd    <= seg_nxt;
            sign_out   <= sign_out_nxt;
            sweep_done <= done_nxt;
        end
    end

endmodule
